systolic_skew_feeder: RTL and testbench
=======================================

# systolic_skew_feeder

Operand feeder for the 4x4 weight-stationary-free (output-stationary) systolic array. Reads K packed words from the A and B global buffers, unpacks each 32-bit word into four 8-bit lanes, and drives the array's north and west edges with the standard diagonal skew (lane j delayed j cycles) and zero padding. It sits between the global buffers and the PE grid, under control of the address-generation FSM, which issues start and waits for done.

## Interface
- ADDR_BITS, 16, width of A/B buffer read index
- DATA_BITS, 32, buffer word width (4 x 8-bit lanes, lane 0 = [31:24], lane 3 = [7:0])
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle request to feed a tile; sampled only in IDLE
- K  in  8  reduction depth (words per operand); latched on accepted start
- busy  out  1  high from cycle after accepted start through done cycle
- done  out  1  one-cycle pulse after the last feed cycle
- A_index  out  ADDR_BITS  A buffer read address
- B_index  out  ADDR_BITS  B buffer read address
- A_data_out  in  DATA_BITS  A buffer read data, valid one cycle after A_index
- B_data_out  in  DATA_BITS  B buffer read data, valid one cycle after B_index
- north0..north3  out  8 each  column inputs to PE row 0 (from A)
- west0..west3  out  8 each  row inputs to PE column 0 (from B)
- feed_valid  out  1  high on every cycle the array must consume north/west

## Operation
- States: IDLE, FEED, DRAIN, DONE.
- IDLE: start=1 and K!=0 -> latch K, rd counter r<=0, go FEED. start with K=0 ignored (no busy, no done). start outside IDLE ignored.
- FEED: A_index=B_index=r (registered); r increments each cycle; after index K-1 is issued go DRAIN.
- Returned word k enters lane 0 output register directly and a j-deep shift chain for lane j (j=1..3); each stage carries a valid bit. Lane output = data if its valid bit set, else 8'h00.
- A and B paths identical: A feeds north_j, B feeds west_j.
- DRAIN: no new reads; shift chains advance until lane 3 emits word K-1, then DONE.
- DONE: done=1 for one cycle, then IDLE.
- Reset (any state, including mid-tile): state IDLE, r=0, all chains and valid bits cleared; busy, done, feed_valid, A_index, B_index, all north/west = 0 the cycle after rst_n sampled low. Partial tile discarded, no done.
- Index arithmetic: r zero-extended to ADDR_BITS; base address is 0 (caller offsets buffers).

## Timing
- Let s = cycle start is sampled. A_index/B_index = k on cycle s+1+k, k=0..K-1.
- north_j/west_j carry word k lane j on cycle s+3+k+j.
- feed_valid high on cycles s+3 .. s+K+5 (K+3 cycles); north/west zero outside word windows.
- done on cycle s+K+6; busy high s+1 .. s+K+6; next start accepted at s+K+7.
- Latency start -> first operand 3 cycles; total tile K+7 cycles including idle return.
- Output registers: no combinational path from A_data_out/B_data_out to north/west.

## Test plan
- K=4, A words 0x01020304, 0x05060708, 0x090A0B0C, 0x0D0E0F10 -> north0 = 01,05,09,0D on s+3..s+6; north3 = 04,08,0C,10 on s+6..s+9; zeros elsewhere; feed_valid s+3..s+9; done at s+10.
- K=1, A=0xAABBCCDD, B=0x11223344 -> north_j/west_j single nonzero on s+3+j (AA/11 ... DD/44); done at s+7.
- K=0 start -> busy and done stay 0, A_index stays 0, outputs 0.
- start pulsed at s+2 during K=4 tile -> ignored; only one done at s+10.
- rst_n low at s+4 of K=4 tile -> next cycle all outputs 0, state IDLE, no done; fresh start then completes normally.
- Back-to-back: start at s+K+7 after K=2 tile -> second tile timing identical relative to its start, no residual nonzero lanes from first tile.

Source files
------------

// File: rtl/systolic_skew_feeder_if.sv
// Bus between the address-generation controller / global buffers and the skew feeder.
// The controller side is the master; the feeder is the slave.
interface systolic_skew_feeder_if #(
  parameter int ADDR_BITS = 16,
  parameter int DATA_BITS = 32
);
  logic                 start;
  logic [7:0]           K;
  logic                 busy;
  logic                 done;
  logic [ADDR_BITS-1:0] A_index;
  logic [ADDR_BITS-1:0] B_index;
  logic [DATA_BITS-1:0] A_data_out;
  logic [DATA_BITS-1:0] B_data_out;
  logic [7:0]           north0, north1, north2, north3;
  logic [7:0]           west0, west1, west2, west3;
  logic                 feed_valid;
  logic [1:0]           dbg_state;

  // start is a single-cycle request with no ready: it is honoured only while
  // busy is low, and completion is signalled by a one-cycle done pulse.
  modport master (
    output start, K, A_data_out, B_data_out,
    input  busy, done, A_index, B_index, feed_valid, dbg_state,
    input  north0, north1, north2, north3, west0, west1, west2, west3
  );

  modport slave (
    input  start, K, A_data_out, B_data_out,
    output busy, done, A_index, B_index, feed_valid, dbg_state,
    output north0, north1, north2, north3, west0, west1, west2, west3
  );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Reads K packed A/B words, splits them into byte lanes and drives the 4x4 array
// edges with diagonal skew (lane j delayed j cycles) and zero padding.
module systolic_skew_feeder #(
  parameter int ADDR_BITS = 16,
  parameter int DATA_BITS = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  systolic_skew_feeder_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, FEED = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [7:0]  k_q;
  logic [7:0]  r_q;
  logic        dv_q;       // buffer read data is a real word this cycle
  logic [2:0]  v_q;        // valid of skew stages 1..3
  logic [3:0]  ov_q;       // valid of lane output registers
  logic [23:0] a_s1, b_s1; // stage 1 carries lanes 1..3
  logic [15:0] a_s2, b_s2; // stage 2 carries lanes 2..3
  logic [7:0]  a_s3, b_s3; // stage 3 carries lane 3
  logic [7:0]  a_o0, a_o1, a_o2, a_o3;
  logic [7:0]  b_o0, b_o1, b_o2, b_o3;
  logic        accept;
  logic        drained;

  assign accept  = (state_q == IDLE) && bus.start && (bus.K != 8'd0);
  // Last word has left lane 3 once nothing upstream of its output is valid.
  assign drained = ov_q[3] && !dv_q && (v_q == 3'b000);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = FEED;
      FEED:    if (r_q == k_q - 8'd1) state_d = DRAIN;
      DRAIN:   if (drained) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= 8'd0;
      r_q     <= 8'd0;
      dv_q    <= 1'b0;
      v_q     <= 3'b000;
      ov_q    <= 4'b0000;
      a_s1    <= '0;
      b_s1    <= '0;
      a_s2    <= '0;
      b_s2    <= '0;
      a_s3    <= '0;
      b_s3    <= '0;
      a_o0    <= '0;
      a_o1    <= '0;
      a_o2    <= '0;
      a_o3    <= '0;
      b_o0    <= '0;
      b_o1    <= '0;
      b_o2    <= '0;
      b_o3    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) k_q <= bus.K;
      // r stays 0 outside FEED so the read index idles at base address 0.
      r_q  <= (state_q == FEED && state_d == FEED) ? r_q + 8'd1 : 8'd0;
      dv_q <= (state_q == FEED);
      v_q  <= {v_q[1:0], dv_q};
      ov_q <= {v_q[2], v_q[1], v_q[0], dv_q};

      a_s1 <= bus.A_data_out[23:0];
      b_s1 <= bus.B_data_out[23:0];
      a_s2 <= a_s1[15:0];
      b_s2 <= b_s1[15:0];
      a_s3 <= a_s2[7:0];
      b_s3 <= b_s2[7:0];

      a_o0 <= bus.A_data_out[31:24];
      b_o0 <= bus.B_data_out[31:24];
      a_o1 <= a_s1[23:16];
      b_o1 <= b_s1[23:16];
      a_o2 <= a_s2[15:8];
      b_o2 <= b_s2[15:8];
      a_o3 <= a_s3;
      b_o3 <= b_s3;
    end
  end

  assign bus.A_index    = {{(ADDR_BITS-8){1'b0}}, r_q};
  assign bus.B_index    = {{(ADDR_BITS-8){1'b0}}, r_q};
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.feed_valid = |ov_q;
  assign bus.dbg_state  = state_q;

  assign bus.north0 = ov_q[0] ? a_o0 : 8'h00;
  assign bus.north1 = ov_q[1] ? a_o1 : 8'h00;
  assign bus.north2 = ov_q[2] ? a_o2 : 8'h00;
  assign bus.north3 = ov_q[3] ? a_o3 : 8'h00;
  assign bus.west0  = ov_q[0] ? b_o0 : 8'h00;
  assign bus.west1  = ov_q[1] ? b_o1 : 8'h00;
  assign bus.west2  = ov_q[2] ? b_o2 : 8'h00;
  assign bus.west3  = ov_q[3] ? b_o3 : 8'h00;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: cycle-by-cycle checks of every output
// against timing expectations derived from the loaded buffer words.
module tb_systolic_skew_feeder;

  logic clk;
  logic rst_n;

  systolic_skew_feeder_if #(.ADDR_BITS(16), .DATA_BITS(32)) bus ();

  systolic_skew_feeder #(.ADDR_BITS(16), .DATA_BITS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // global buffer model: one-cycle read latency
  logic [31:0] a_mem [16];
  logic [31:0] b_mem [16];

  always_ff @(posedge clk) begin
    bus.A_data_out <= a_mem[bus.A_index[3:0]];
    bus.B_data_out <= b_mem[bus.B_index[3:0]];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // c = cycles since the start cycle s; act = a tile of k words is in flight
  task automatic check_cycle(input int c, input int k, input bit act);
    logic [7:0]  nv [4];
    logic [7:0]  wv [4];
    logic [31:0] aw, bw;
    logic [7:0]  ea, eb;
    int          w;
    logic [1:0]  es;
    nv[0] = bus.north0; nv[1] = bus.north1; nv[2] = bus.north2; nv[3] = bus.north3;
    wv[0] = bus.west0;  wv[1] = bus.west1;  wv[2] = bus.west2;  wv[3] = bus.west3;
    for (int j = 0; j < 4; j++) begin
      w  = c - 3 - j;
      ea = 8'h00;
      eb = 8'h00;
      if (act && w >= 0 && w < k) begin
        aw = a_mem[w];
        bw = b_mem[w];
        ea = aw[31-8*j -: 8];
        eb = bw[31-8*j -: 8];
      end
      chk($sformatf("c%0d north%0d", c, j), {24'h0, nv[j]}, {24'h0, ea});
      chk($sformatf("c%0d west%0d", c, j), {24'h0, wv[j]}, {24'h0, eb});
    end
    chk($sformatf("c%0d busy", c), {31'h0, bus.busy}, {31'h0, act && c >= 1 && c <= k + 6});
    chk($sformatf("c%0d done", c), {31'h0, bus.done}, {31'h0, act && c == k + 6});
    chk($sformatf("c%0d feed_valid", c), {31'h0, bus.feed_valid},
        {31'h0, act && c >= 3 && c <= k + 5});
    chk($sformatf("c%0d A_index", c), {16'h0, bus.A_index},
        (act && c >= 1 && c <= k) ? 32'(c - 1) : 32'h0);
    chk($sformatf("c%0d B_index", c), {16'h0, bus.B_index},
        (act && c >= 1 && c <= k) ? 32'(c - 1) : 32'h0);
    if (!act)             es = 2'd0;
    else if (c <= k)      es = 2'd1;
    else if (c <= k + 5)  es = 2'd2;
    else if (c == k + 6)  es = 2'd3;
    else                  es = 2'd0;
    chk($sformatf("c%0d state", c), {30'h0, bus.dbg_state}, {30'h0, es});
  endtask

  // Called at a negedge; start is held high for the rest of this cycle.
  task automatic run_tile(input int k, input int last, input int glitch_at, input int rst_at);
    bit killed;
    killed    = 1'b0;
    bus.start = 1'b1;
    bus.K     = 8'(k);
    @(negedge clk);
    for (int c = 1; c <= last; c++) begin
      if (rst_at > 0 && c == rst_at + 1) killed = 1'b1;
      check_cycle(c, k, (k != 0) && !killed);
      bus.start = (c == glitch_at);
      rst_n     = (c == rst_at) ? 1'b0 : 1'b1;
      if (c < last) @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.K     = 8'd0;
    for (int i = 0; i < 16; i++) begin
      a_mem[i] = 32'h0;
      b_mem[i] = 32'h0;
    end

    // reset state
    repeat (3) @(negedge clk);
    check_cycle(0, 0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_cycle(0, 0, 1'b0);

    // K=4 basic tile
    a_mem[0] = 32'h01020304; a_mem[1] = 32'h05060708;
    a_mem[2] = 32'h090A0B0C; a_mem[3] = 32'h0D0E0F10;
    b_mem[0] = 32'h11121314; b_mem[1] = 32'h21222324;
    b_mem[2] = 32'h31323334; b_mem[3] = 32'h41424344;
    run_tile(4, 13, -1, -1);

    // K=1 single word
    a_mem[0] = 32'hAABBCCDD;
    b_mem[0] = 32'h11223344;
    run_tile(1, 10, -1, -1);

    // K=0 request is ignored
    run_tile(0, 8, -1, -1);

    // start pulsed again mid-tile is ignored
    a_mem[0] = 32'h01020304;
    b_mem[0] = 32'h11121314;
    run_tile(4, 13, 2, -1);

    // reset mid-tile, then a fresh tile completes normally
    run_tile(4, 13, -1, 4);
    run_tile(4, 13, -1, -1);

    // back-to-back K=2 tiles with different data
    a_mem[0] = 32'hC1C2C3C4; a_mem[1] = 32'hD1D2D3D4;
    b_mem[0] = 32'hE1E2E3E4; b_mem[1] = 32'hF1F2F3F4;
    run_tile(2, 9, -1, -1);
    a_mem[0] = 32'h5A5B5C5D; a_mem[1] = 32'h6A6B6C6D;
    b_mem[0] = 32'h7A7B7C7D; b_mem[1] = 32'h8A8B8C8D;
    run_tile(2, 11, -1, -1);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
